// File: rtl/wb_queue_if.sv
// wb_queue_if: pipeline/multi-cycle writeback requests, register-file write port and bypass lookup.
interface wb_queue_if;
    logic        p_valid;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic [31:0] p_pc;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_pc;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] rf_pc;
    logic        stall;
    logic [4:0]  q_a;
    logic        q_hit;
    logic [31:0] q_data;
    modport master (
        output p_valid, p_addr, p_data, p_pc, m_valid, m_addr, m_data, m_pc, q_a,
        input  m_ready, stall, rf_we, rf_a3, rf_wd, rf_pc, q_hit, q_data
    );
    modport slave (
        input  p_valid, p_addr, p_data, p_pc, m_valid, m_addr, m_data, m_pc, q_a,
        output m_ready, stall, rf_we, rf_a3, rf_wd, rf_pc, q_hit, q_data
    );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: 4-entry in-order writeback queue merging pipeline and multi-cycle results onto one RF port.
// Define WB_TRACE_EN to print every register-file write.
module wb_queue (
    input logic       clk,
    input logic       reset,
    wb_queue_if.slave bus
);
    logic [4:0]  f_addr [4];
    logic [31:0] f_data [4];
    logic [31:0] f_pc   [4];
    logic [2:0]  count;
    logic [1:0]  rd, wr;
    logic        p_en, m_en, deq;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd, rf_pc;
    logic        hit;
    logic [31:0] hit_data;
    assign bus.stall   = count >= 3'd3;
    assign bus.m_ready = count <= 3'd2;
    // Writes to $0 are dropped here, but the m handshake still completes.
    assign p_en = bus.p_valid && bus.p_addr != 5'd0;
    assign m_en = bus.m_valid && bus.m_ready && bus.m_addr != 5'd0;
    assign deq  = count != 3'd0;
    assign bus.rf_we = rf_we;
    assign bus.rf_a3 = rf_a3;
    assign bus.rf_wd = rf_wd;
    assign bus.rf_pc = rf_pc;
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 3'd0;
            rd    <= 2'd0;
            wr    <= 2'd0;
            rf_we <= 1'b0;
            rf_a3 <= 5'd0;
            rf_wd <= 32'd0;
            rf_pc <= 32'd0;
        end else begin
            if (p_en) begin
                f_addr[wr] <= bus.p_addr;
                f_data[wr] <= bus.p_data;
                f_pc[wr]   <= bus.p_pc;
            end
            if (m_en) begin
                f_addr[wr + 2'(p_en)] <= bus.m_addr;
                f_data[wr + 2'(p_en)] <= bus.m_data;
                f_pc[wr + 2'(p_en)]   <= bus.m_pc;
            end
            wr    <= wr + 2'(p_en) + 2'(m_en);
            rd    <= rd + 2'(deq);
            count <= count + 3'(p_en) + 3'(m_en) - 3'(deq);
            rf_we <= deq;
            if (deq) begin
                rf_a3 <= f_addr[rd];
                rf_wd <= f_data[rd];
                rf_pc <= f_pc[rd];
            end
        end
    end
    // Scan oldest to newest so the youngest match wins; the RF register is older than any entry.
    always_comb begin
        hit      = rf_we && rf_a3 == bus.q_a;
        hit_data = hit ? rf_wd : 32'd0;
        for (int i = 0; i < 4; i++)
            if (3'(i) < count && f_addr[rd + 2'(i)] == bus.q_a) begin
                hit      = 1'b1;
                hit_data = f_data[rd + 2'(i)];
            end
    end
    assign bus.q_hit  = hit && bus.q_a != 5'd0;
    assign bus.q_data = bus.q_hit ? hit_data : 32'd0;
`ifdef WB_TRACE_EN
    always_ff @(posedge clk)
        if (rf_we) $display("@%08h: $%d <= %08h", rf_pc, rf_a3, rf_wd);
`endif
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed stimulus with a scoreboard of expected register-file writes.
module tb_wb_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    wb_queue_if bus();
    wb_queue dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef logic [68:0] ent_t;
    ent_t exp_q[$];
    int checks = 0;
    int fails = 0;
    int mcount = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    // Monitor: every RF write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        ent_t e;
        if (bus.rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected rf write: got a3=%0d wd=%h, expected none", bus.rf_a3, bus.rf_wd);
            end else begin
                e = exp_q.pop_front();
                chk("sb rf_a3", 32'(bus.rf_a3), 32'(e[68:64]));
                chk("sb rf_wd", bus.rf_wd, e[63:32]);
                chk("sb rf_pc", bus.rf_pc, e[31:0]);
            end
        end
    end
    task automatic step(input logic pv, input logic [4:0] pa, input logic [31:0] pd, input logic [31:0] pp,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md, input logic [31:0] mp,
                        output logic acc);
        bus.p_valid = pv; bus.p_addr = pa; bus.p_data = pd; bus.p_pc = pp;
        bus.m_valid = mv; bus.m_addr = ma; bus.m_data = md; bus.m_pc = mp;
        acc = mv && mcount <= 2;
        #1;
        chk("stall", 32'(bus.stall), 32'(mcount >= 3));
        chk("m_ready", 32'(bus.m_ready), 32'(mcount <= 2));
        if (pv && pa != 5'd0) exp_q.push_back({pa, pd, pp});
        if (acc && ma != 5'd0) exp_q.push_back({ma, md, mp});
        @(posedge clk);
        #1;
        mcount += int'(pv && pa != 5'd0) + int'(acc && ma != 5'd0) - int'(mcount > 0);
        bus.p_valid = 1'b0;
        bus.m_valid = 1'b0;
    endtask
    task automatic idle();
        logic a;
        step(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, a);
    endtask
    task automatic qchk(input logic [4:0] a, input logic h, input logic [31:0] d);
        bus.q_a = a;
        #1;
        chk("q_hit", 32'(bus.q_hit), 32'(h));
        chk("q_data", bus.q_data, d);
    endtask
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end, expected finish");
        $fatal(1);
    end
    initial begin
        logic acc;
        int mi;
        bus.p_valid = 0; bus.p_addr = 0; bus.p_data = 0; bus.p_pc = 0;
        bus.m_valid = 0; bus.m_addr = 0; bus.m_data = 0; bus.m_pc = 0; bus.q_a = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rf_we", 32'(bus.rf_we), 32'd0);
        chk("reset rf_a3", 32'(bus.rf_a3), 32'd0);
        chk("reset rf_wd", bus.rf_wd, 32'd0);
        chk("reset rf_pc", bus.rf_pc, 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        chk("reset m_ready", 32'(bus.m_ready), 32'd1);
        qchk(5'd5, 1'b0, 32'd0);
        reset = 1'b0;
        // Single write: two-cycle latency, one-cycle pulse.
        step(1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'd0, 32'd0, acc);
        chk("latency rf_we", 32'(bus.rf_we), 32'd0);
        idle();
        chk("single rf_we", 32'(bus.rf_we), 32'd1);
        chk("single rf_a3", 32'(bus.rf_a3), 32'd5);
        chk("single rf_wd", bus.rf_wd, 32'h1234);
        chk("single rf_pc", bus.rf_pc, 32'h3000);
        idle();
        chk("single end rf_we", 32'(bus.rf_we), 32'd0);
        // No same-cycle bypass of an incoming request.
        bus.p_valid = 1'b1; bus.p_addr = 5'd3; bus.q_a = 5'd3;
        #1;
        chk("no input bypass", 32'(bus.q_hit), 32'd0);
        // Both sources in one cycle: pipeline first, youngest wins the lookup.
        step(1'b1, 5'd3, 32'hAA, 32'h100, 1'b1, 5'd3, 32'hBB, 32'h104, acc);
        qchk(5'd3, 1'b1, 32'hBB);
        idle();
        chk("dual first rf_wd", bus.rf_wd, 32'hAA);
        qchk(5'd3, 1'b1, 32'hBB);
        idle();
        chk("dual second rf_wd", bus.rf_wd, 32'hBB);
        qchk(5'd3, 1'b1, 32'hBB);
        idle();
        qchk(5'd3, 1'b0, 32'd0);
        // Distinct addresses both visible in the FIFO.
        step(1'b1, 5'd9, 32'h11, 32'h200, 1'b1, 5'd10, 32'h22, 32'h204, acc);
        qchk(5'd9, 1'b1, 32'h11);
        qchk(5'd10, 1'b1, 32'h22);
        qchk(5'd12, 1'b0, 32'd0);
        repeat (3) idle();
        // Zero register is never written and never hits.
        step(1'b1, 5'd0, 32'hFFFF, 32'h300, 1'b1, 5'd0, 32'hEEEE, 32'h304, acc);
        qchk(5'd0, 1'b0, 32'd0);
        repeat (2) idle();
        chk("zero rf_we", 32'(bus.rf_we), 32'd0);
        // Back-pressure: both sources busy, pipeline honours stall, m holds until accepted.
        mi = 0;
        for (int k = 0; k < 12; k++) begin
            step(mcount < 3, 5'(16 + k % 8), 32'h1000 + 32'(k), 32'h4000 + 32'(4 * k),
                 1'b1, 5'(1 + mi % 8), 32'h2000 + 32'(mi), 32'h5000 + 32'(4 * mi), acc);
            if (acc) mi++;
        end
        repeat (5) idle();
        chk("drained", 32'(exp_q.size()), 32'd0);
        // Reset with three entries queued: none of them may ever be written.
        step(1'b1, 5'd6, 32'h61, 32'h600, 1'b1, 5'd7, 32'h71, 32'h700, acc);
        step(1'b1, 5'd8, 32'h81, 32'h800, 1'b1, 5'd11, 32'hB1, 32'hB00, acc);
        qchk(5'd11, 1'b1, 32'hB1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        mcount = 0;
        reset = 1'b0;
        chk("midreset rf_we", 32'(bus.rf_we), 32'd0);
        chk("midreset rf_a3", 32'(bus.rf_a3), 32'd0);
        chk("midreset stall", 32'(bus.stall), 32'd0);
        chk("midreset m_ready", 32'(bus.m_ready), 32'd1);
        qchk(5'd8, 1'b0, 32'd0);
        qchk(5'd11, 1'b0, 32'd0);
        repeat (4) idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
